// File: rtl/pam_frame_serializer.sv
// PAM frame serializer: gathers CHANNELS words of BYTES_PER_WORD bytes from a show-ahead FIFO
// once per frame tick, then shifts them out with a generated bit clock and active-low frame sync.
module pam_frame_serializer #(
  parameter int unsigned CLKS_PER_FRAME = 400,
  parameter int unsigned CLKS_PER_BCLK  = 4,
  parameter int unsigned BYTES_PER_WORD = 3,
  parameter int unsigned CHANNELS       = 2,
  parameter bit          MSB_FIRST      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_read,
  output logic       nsync,
  output logic       bclk,
  output logic       sdata,
  output logic       frame_done,
  output logic       underrun,
  output logic       late
);

  localparam int unsigned TOTAL_BYTES = BYTES_PER_WORD * CHANNELS;
  localparam int unsigned TOTAL_BITS  = 8 * TOTAL_BYTES;
  localparam int unsigned WORD_BITS   = 8 * BYTES_PER_WORD;
  localparam int unsigned FW = $clog2(CLKS_PER_FRAME);
  localparam int unsigned BW = $clog2(TOTAL_BYTES + 1);
  localparam int unsigned PW = $clog2(CLKS_PER_BCLK);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned KW = $clog2(WORD_BITS);
  localparam int unsigned IW = $clog2(TOTAL_BITS);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [TOTAL_BITS-1:0] buf_q, buf_d;
  logic                  pend_q, pend_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic [CW-1:0]         word_q, word_d;
  logic [KW-1:0]         wbit_q, wbit_d;
  logic                  nsync_q, nsync_d;
  logic                  bclk_q, bclk_d;
  logic                  sdata_q, sdata_d;
  logic                  done_q, done_d;
  logic                  under_q, under_d;
  logic                  late_q, late_d;

  logic          tick;
  logic          last_byte;
  logic          last_bit;
  logic [IW-1:0] wr_sel;

  // Byte i of the frame lives at buf[8*i +: 8]; byte 0 of each word is its most significant byte.
  function automatic logic frame_bit(input logic [TOTAL_BITS-1:0] v, input logic [CW-1:0] w,
                                     input logic [KW-1:0] k);
    int unsigned   p;
    int unsigned   bi;
    logic [IW-1:0] sel;
    p   = MSB_FIRST ? (WORD_BITS - 1 - 32'(k)) : 32'(k);
    bi  = 32'(w) * BYTES_PER_WORD + (BYTES_PER_WORD - 1) - p / 8;
    sel = IW'(bi * 8 + p % 8);
    return v[sel];
  endfunction

  always_comb begin
    tick      = enable && (frm_q == FW'(CLKS_PER_FRAME - 1));
    last_byte = (byte_q == BW'(TOTAL_BYTES - 1));
    last_bit  = (word_q == CW'(CHANNELS - 1)) && (wbit_q == KW'(WORD_BITS - 1));
    wr_sel    = IW'({byte_q, 3'b000});

    state_d   = state_q;
    frm_d     = frm_q;
    byte_d    = byte_q;
    buf_d     = buf_q;
    pend_d    = pend_q;
    ph_d      = ph_q;
    word_d    = word_q;
    wbit_d    = wbit_q;
    nsync_d   = nsync_q;
    bclk_d    = bclk_q;
    sdata_d   = sdata_q;
    done_d    = done_q;
    under_d   = under_q;
    late_d    = late_q;
    fifo_read = 1'b0;

    if (enable) begin
      frm_d   = tick ? '0 : frm_q + FW'(1);
      done_d  = 1'b0;
      under_d = 1'b0;
      late_d  = 1'b0;

      unique case (state_q)
        StIdle: begin
          if (tick) begin
            state_d = StLoad;
            byte_d  = '0;
          end
        end

        StLoad: begin
          // A tick only blocks the pop when the frame would still be incomplete afterwards.
          if (!fifo_empty && (!tick || last_byte)) begin
            fifo_read            = 1'b1;
            buf_d[wr_sel +: 8]   = fifo_data;
            if (last_byte) begin
              state_d = StShift;
              ph_d    = '0;
              word_d  = '0;
              wbit_d  = '0;
              nsync_d = 1'b0;
              bclk_d  = 1'b0;
              sdata_d = frame_bit(buf_d, '0, '0);
              if (tick) begin
                late_d = 1'b1;
                pend_d = 1'b1;
              end
            end else begin
              byte_d = byte_q + BW'(1);
            end
          end else if (tick) begin
            under_d = 1'b1;
            byte_d  = '0;
          end
        end

        StShift: begin
          if (tick) begin
            late_d = 1'b1;
            pend_d = 1'b1;
          end
          if (ph_q == PW'(CLKS_PER_BCLK - 1)) begin
            ph_d = '0;
            if (last_bit) begin
              nsync_d = 1'b1;
              bclk_d  = 1'b1;
              sdata_d = 1'b0;
              done_d  = 1'b1;
              byte_d  = '0;
              pend_d  = 1'b0;
              state_d = (pend_q || tick) ? StLoad : StIdle;
            end else begin
              if (wbit_q == KW'(WORD_BITS - 1)) begin
                wbit_d = '0;
                word_d = word_q + CW'(1);
              end else begin
                wbit_d = wbit_q + KW'(1);
              end
              bclk_d  = 1'b0;
              sdata_d = frame_bit(buf_q, word_d, wbit_d);
            end
          end else begin
            ph_d = ph_q + PW'(1);
            if (ph_q == PW'(CLKS_PER_BCLK / 2 - 1)) begin
              bclk_d = 1'b1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      frm_q   <= '0;
      byte_q  <= '0;
      buf_q   <= '0;
      pend_q  <= 1'b0;
      ph_q    <= '0;
      word_q  <= '0;
      wbit_q  <= '0;
      nsync_q <= 1'b1;
      bclk_q  <= 1'b1;
      sdata_q <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
      byte_q  <= byte_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      ph_q    <= ph_d;
      word_q  <= word_d;
      wbit_q  <= wbit_d;
      nsync_q <= nsync_d;
      bclk_q  <= bclk_d;
      sdata_q <= sdata_d;
      done_q  <= done_d;
      under_q <= under_d;
      late_q  <= late_d;
    end
  end

  assign nsync      = nsync_q;
  assign bclk       = bclk_q;
  assign sdata      = sdata_q;
  assign frame_done = done_q;
  assign underrun   = under_q;
  assign late       = late_q;

endmodule

// File: tb/tb_pam_frame_serializer.sv
// Directed bench: DUT A is 1 channel x 3 bytes MSB-first, DUT B is 2 channels x 1 byte LSB-first,
// both at 200 clk per frame and 4 clk per bit. Cycle numbers below are negedge counts after release.
module tb_pam_frame_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;

  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       empty_a = 1'b1, empty_b = 1'b1;
  logic       rd_a, nsync_a, bclk_a, sdata_a, done_a, under_a, late_a;
  logic       rd_b, nsync_b, bclk_b, sdata_b, done_b, under_b, late_b;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int cyc = 0;
  int rel = 0;
  int errors = 0;
  int checks = 0;

  int          rd_cyc_a[$];
  int          done_cyc_a[$];
  int          late_cnt_a, late_cyc_a, under_cnt_a, under_cyc_a;
  int          run_cur_a, run_last_a, runs_a;
  logic [63:0] bits_a, bits_b;
  int          nbits_a, nbits_b, done_cnt_b;
  logic        pn_a = 1'b1, pb_a = 1'b1, pb_b = 1'b1;
  logic        pa_s, pb_s;

  pam_frame_serializer #(
    .CLKS_PER_FRAME(200), .CLKS_PER_BCLK(4), .BYTES_PER_WORD(3), .CHANNELS(1), .MSB_FIRST(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .fifo_data(data_a), .fifo_empty(empty_a),
    .fifo_read(rd_a), .nsync(nsync_a), .bclk(bclk_a), .sdata(sdata_a),
    .frame_done(done_a), .underrun(under_a), .late(late_a)
  );

  pam_frame_serializer #(
    .CLKS_PER_FRAME(200), .CLKS_PER_BCLK(4), .BYTES_PER_WORD(1), .CHANNELS(2), .MSB_FIRST(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .fifo_data(data_b), .fifo_empty(empty_b),
    .fifo_read(rd_b), .nsync(nsync_b), .bclk(bclk_b), .sdata(sdata_b),
    .frame_done(done_b), .underrun(under_b), .late(late_b)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    empty_a = (qa.size() == 0);
    data_a  = empty_a ? 8'h00 : qa[0];
    empty_b = (qb.size() == 0);
    data_b  = empty_b ? 8'h00 : qb[0];
  endtask

  // Show-ahead FIFO model: the head advances just after the edge that captured it.
  always @(posedge clk) begin
    pa_s = rd_a;
    pb_s = rd_b;
    cyc  = cyc + 1;
    #1;
    if (pa_s && qa.size() > 0) void'(qa.pop_front());
    if (pb_s && qb.size() > 0) void'(qb.pop_front());
    refresh();
  end

  always @(negedge clk) begin
    if (rd_a) rd_cyc_a.push_back(cyc);
    if (done_a) done_cyc_a.push_back(cyc);
    if (late_a) begin late_cnt_a++; late_cyc_a = cyc; end
    if (under_a) begin under_cnt_a++; under_cyc_a = cyc; end
    if (!nsync_a) run_cur_a++;
    else if (!pn_a) begin run_last_a = run_cur_a; runs_a++; run_cur_a = 0; end
    if (bclk_a && !pb_a) begin bits_a = {bits_a[62:0], sdata_a}; nbits_a++; end
    pn_a = nsync_a;
    pb_a = bclk_a;
    if (done_b) done_cnt_b++;
    if (bclk_b && !pb_b) begin bits_b = {bits_b[62:0], sdata_b}; nbits_b++; end
    pb_b = bclk_b;
  end

  task automatic clear_logs();
    rd_cyc_a.delete(); done_cyc_a.delete();
    late_cnt_a = 0; late_cyc_a = 0; under_cnt_a = 0; under_cyc_a = 0;
    run_cur_a = 0; run_last_a = 0; runs_a = 0;
    bits_a = '0; bits_b = '0; nbits_a = 0; nbits_b = 0; done_cnt_b = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    qa.delete();
    qb.delete();
    refresh();
    repeat (3) @(negedge clk);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    rel = cyc;
    clear_logs();
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] b);
    qa.push_back(b);
    refresh();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (nsync_a !== 1'b1) begin errors++; $display("FAIL reset_nsync: got %b want 1", nsync_a); end
    if (bclk_a !== 1'b1) begin errors++; $display("FAIL reset_bclk: got %b want 1", bclk_a); end
    if (sdata_a !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", sdata_a); end
    if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", rd_a); end
    if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    if (under_a !== 1'b0) begin errors++; $display("FAIL reset_under: got %b want 0", under_a); end
    if (late_a !== 1'b0) begin errors++; $display("FAIL reset_late: got %b want 0", late_a); end
  endtask

  task automatic test_single_msb();
    do_reset();
    push_a(8'hA5); push_a(8'h3C); push_a(8'h0F);
    release_rst();
    wait_until(rel + 310);
    checks += 8;
    if (rd_cyc_a.size() !== 3)
      begin errors++; $display("FAIL msb_reads: got %0d want 3", rd_cyc_a.size()); end
    if (rd_cyc_a[0] - rel !== 200)
      begin errors++; $display("FAIL msb_first_tick: got %0d want 200", rd_cyc_a[0] - rel); end
    if (nbits_a !== 24) begin errors++; $display("FAIL msb_nbits: got %0d want 24", nbits_a); end
    if (bits_a[23:0] !== 24'hA53C0F)
      begin errors++; $display("FAIL msb_bits: got %h want a53c0f", bits_a[23:0]); end
    if (run_last_a !== 96) begin errors++; $display("FAIL msb_nsync_len: got %0d want 96", run_last_a); end
    if (done_cyc_a.size() !== 1 || done_cyc_a[0] - rel !== 299)
      begin errors++; $display("FAIL msb_done: got n=%0d at %0d want 1 at 299",
                               done_cyc_a.size(), done_cyc_a[0] - rel); end
    if (late_cnt_a !== 0) begin errors++; $display("FAIL msb_late: got %0d want 0", late_cnt_a); end
    if (under_cnt_a !== 0) begin errors++; $display("FAIL msb_under: got %0d want 0", under_cnt_a); end
  endtask

  task automatic test_two_channel_lsb();
    do_reset();
    qb.push_back(8'h01); qb.push_back(8'h80); refresh();
    release_rst();
    wait_until(rel + 300);
    checks += 3;
    if (nbits_b !== 16) begin errors++; $display("FAIL lsb_nbits: got %0d want 16", nbits_b); end
    if (bits_b[15:0] !== 16'h8001)
      begin errors++; $display("FAIL lsb_bits: got %b want 1000000000000001", bits_b[15:0]); end
    if (done_cnt_b !== 1) begin errors++; $display("FAIL lsb_done: got %0d want 1", done_cnt_b); end
  endtask

  task automatic test_underrun();
    do_reset();
    push_a(8'hA5);
    release_rst();
    wait_until(rel + 410);
    checks += 3;
    if (under_cnt_a !== 1 || under_cyc_a - rel !== 400)
      begin errors++; $display("FAIL underrun_pulse: got n=%0d at %0d want 1 at 400",
                               under_cnt_a, under_cyc_a - rel); end
    if (runs_a !== 0 || run_cur_a !== 0)
      begin errors++; $display("FAIL underrun_nsync: got runs=%0d want 0", runs_a); end
    if (nbits_a !== 0) begin errors++; $display("FAIL underrun_bits: got %0d want 0", nbits_a); end
    push_a(8'h11); push_a(8'h22); push_a(8'h33);
    wait_until(rel + 520);
    checks += 3;
    if (bits_a[23:0] !== 24'h112233 || nbits_a !== 24)
      begin errors++; $display("FAIL underrun_next_bits: got %h n=%0d want 112233 n=24",
                               bits_a[23:0], nbits_a); end
    if (done_cyc_a.size() !== 1 || done_cyc_a[0] - rel !== 509)
      begin errors++; $display("FAIL underrun_next_done: got n=%0d at %0d want 1 at 509",
                               done_cyc_a.size(), done_cyc_a[0] - rel); end
    if (under_cnt_a !== 1) begin errors++; $display("FAIL underrun_once: got %0d want 1", under_cnt_a); end
  endtask

  task automatic test_stall_late();
    int n;
    do_reset();
    release_rst();
    wait_until(rel + 350);
    push_a(8'h5A); push_a(8'hC3); push_a(8'hE7);
    wait_until(rel + 420);
    push_a(8'h01); push_a(8'h02); push_a(8'h03);
    wait_until(rel + 560);
    n = rd_cyc_a.size();
    checks += 5;
    if (late_cnt_a !== 1 || late_cyc_a - rel !== 400)
      begin errors++; $display("FAIL late_pulse: got n=%0d at %0d want 1 at 400",
                               late_cnt_a, late_cyc_a - rel); end
    if (done_cyc_a.size() !== 2 || done_cyc_a[0] - rel !== 449 || done_cyc_a[1] - rel !== 548)
      begin errors++; $display("FAIL late_done: got n=%0d at %0d,%0d want 2 at 449,548",
                               done_cyc_a.size(), done_cyc_a[0] - rel, done_cyc_a[1] - rel); end
    if (n < 3 || rd_cyc_a[n-3] - rel !== 449 || rd_cyc_a[n-1] - rel !== 451)
      begin errors++; $display("FAIL late_no_idle_gap: got first reread %0d want 449",
                               (n >= 3) ? rd_cyc_a[n-3] - rel : -1); end
    if (bits_a[47:0] !== 48'h5AC3E7010203 || nbits_a !== 48)
      begin errors++; $display("FAIL late_bits: got %h n=%0d want 5ac3e7010203 n=48",
                               bits_a[47:0], nbits_a); end
    if (under_cnt_a !== 0) begin errors++; $display("FAIL late_under: got %0d want 0", under_cnt_a); end
  endtask

  task automatic test_enable();
    do_reset();
    push_a(8'hA5); push_a(8'h3C); push_a(8'h0F);
    release_rst();
    // Offset 27 into the shift: bit 6 (a 0), second half of its period (bclk high).
    wait_until(rel + 230);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (nsync_a !== 1'b0 || bclk_a !== 1'b1 || sdata_a !== 1'b0 || rd_a !== 1'b0)
        begin errors++; $display("FAIL enable_hold: cycle %0d got nsync=%b bclk=%b sdata=%b rd=%b want 0 1 0 0",
                                 i, nsync_a, bclk_a, sdata_a, rd_a); end
    end
    enable = 1'b1;
    wait_until(rel + 320);
    checks += 3;
    if (run_last_a !== 106) begin errors++; $display("FAIL enable_len: got %0d want 106", run_last_a); end
    if (bits_a[23:0] !== 24'hA53C0F || nbits_a !== 24)
      begin errors++; $display("FAIL enable_bits: got %h n=%0d want a53c0f n=24", bits_a[23:0], nbits_a); end
    if (done_cyc_a.size() !== 1 || done_cyc_a[0] - rel !== 309)
      begin errors++; $display("FAIL enable_done: got n=%0d at %0d want 1 at 309",
                               done_cyc_a.size(), done_cyc_a[0] - rel); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_a(8'hA5); push_a(8'h3C); push_a(8'h0F);
    release_rst();
    wait_until(rel + 223);
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (nsync_a !== 1'b1 || bclk_a !== 1'b1 || sdata_a !== 1'b0)
      begin errors++; $display("FAIL rstmid_outputs: got nsync=%b bclk=%b sdata=%b want 1 1 0",
                               nsync_a, bclk_a, sdata_a); end
    if (done_cyc_a.size() !== 0)
      begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cyc_a.size()); end
    @(negedge clk);
    release_rst();
    wait_until(rel + 5);
    push_a(8'h11); push_a(8'h22); push_a(8'h33);
    wait_until(rel + 310);
    checks += 3;
    if (rd_cyc_a.size() !== 3 || rd_cyc_a[0] - rel !== 200)
      begin errors++; $display("FAIL rstmid_tick: got n=%0d first at %0d want 3 first at 200",
                               rd_cyc_a.size(), rd_cyc_a[0] - rel); end
    if (bits_a[23:0] !== 24'h112233 || nbits_a !== 24)
      begin errors++; $display("FAIL rstmid_bits: got %h n=%0d want 112233 n=24", bits_a[23:0], nbits_a); end
    if (done_cyc_a.size() !== 1 || done_cyc_a[0] - rel !== 299)
      begin errors++; $display("FAIL rstmid_done: got n=%0d at %0d want 1 at 299",
                               done_cyc_a.size(), done_cyc_a[0] - rel); end
  endtask

  initial begin
    clear_logs();
    refresh();
    test_reset();
    test_single_msb();
    test_two_channel_lsb();
    test_underrun();
    test_stall_late();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
